uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, next generation of the single-word TX engine: adds a write-side FIFO, a built-in baud divider, a runtime-selectable frame length, one or two stop bits and optional parity. Sits between the controller's write port and the serial line. Frame start is gated by the far end's ready-to-send. Already-encoded words (e.g. SECDED codewords) are accepted as-is; the block does no encoding.

---
 rtl/uart_tx_fifo_if.sv | 33 +++
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-port and status bundle for uart_tx_fifo: the controller drives the
// master side, the transmitter implements the slave side.
interface uart_tx_fifo_if #(
  parameter int DATA_W     = 14,
  parameter int FIFO_DEPTH = 4
);
  localparam int LEN_W = $clog2(DATA_W + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [LEN_W-1:0]  data_len;
  logic              stop2;
  logic              parity_en;
  logic              parity_odd;
  logic              rx_rts;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [2:0]        state;
  logic              busy;
  logic              done;
  logic              serial_out;

  modport master (
    output wr_en, wr_data, data_len, stop2, parity_en, parity_odd, rx_rts,
    input  full, count, state, busy, done, serial_out
  );

  modport slave (
    input  wr_en, wr_data, data_len, stop2, parity_en, parity_odd, rx_rts,
    output full, count, state, busy, done, serial_out
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, baud divider, runtime frame length and 1/2 stop bits.
// Parity generation is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int DATA_W       = 14,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int LEN_W  = $clog2(DATA_W + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [LEN_W-1:0]  bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              stop2_q, par_en_q, par_odd_q, par_acc_q;
  logic              ser_q, done_q, busy_q;

  logic push, pop, baud_last, last_stop, stop_end;

  assign push      = bus.wr_en && !full_q;
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_stop = (bit_q == (stop2_q ? LEN_W'(1) : LEN_W'(0)));
  assign stop_end  = (state_q == S_STOP) && baud_last && last_stop;
  // A pending word may start straight out of the final stop bit, so frames chain with no gap.
  assign pop       = (count_q != '0) && bus.rx_rts && ((state_q == S_IDLE) || stop_end);

  always_comb begin
    len_d = bus.data_len;
    if (bus.data_len == '0 || bus.data_len > LEN_W'(DATA_W)) len_d = LEN_W'(DATA_W);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      len_q     <= '0;
      stop2_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc_q <= 1'b0;
      ser_q     <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // done is raised on the edge entering the last cycle of the final stop bit.
      done_q <= (state_q == S_STOP) && last_stop && (baud_q == BAUD_W'(CLKS_PER_BIT - 2));
      if (pop) begin
        state_q   <= S_START;
        baud_q    <= '0;
        bit_q     <= '0;
        shreg_q   <= mem_q[rd_ptr_q];
        len_q     <= len_d;
        stop2_q   <= bus.stop2;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= bus.parity_en;
`else
        par_en_q  <= 1'b0;
`endif
        par_odd_q <= bus.parity_odd;
        par_acc_q <= 1'b0;
        ser_q     <= 1'b0;
        busy_q    <= 1'b1;
      end else if (state_q != S_IDLE && !baud_last) begin
        baud_q <= baud_q + BAUD_W'(1);
      end else begin
        baud_q <= '0;
        case (state_q)
          S_IDLE: ser_q <= 1'b1;
          S_START: begin
            state_q   <= S_DATA;
            ser_q     <= shreg_q[DATA_W-1];
            par_acc_q <= par_acc_q ^ shreg_q[DATA_W-1];
            shreg_q   <= shreg_q << 1;
          end
          S_DATA: begin
            if (bit_q == len_q - LEN_W'(1)) begin
              bit_q <= '0;
              if (par_en_q) begin
                state_q <= S_PARITY;
                ser_q   <= par_acc_q ^ par_odd_q;
              end else begin
                state_q <= S_STOP;
                ser_q   <= 1'b1;
              end
            end else begin
              bit_q     <= bit_q + LEN_W'(1);
              ser_q     <= shreg_q[DATA_W-1];
              par_acc_q <= par_acc_q ^ shreg_q[DATA_W-1];
              shreg_q   <= shreg_q << 1;
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
            bit_q   <= '0;
            ser_q   <= 1'b1;
          end
          S_STOP: begin
            if (last_stop) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + LEN_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ser_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.full       = full_q;
  assign bus.count      = count_q;
  assign bus.state      = state_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.serial_out = ser_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a line
// monitor decodes serial_out cycle by cycle and compares against them.
module tb_uart_tx_fifo;
  localparam int DATA_W = 14;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] d;
    int                len;
    bit                par;
    bit                odd;
    bit                st2;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_len = 0;
  frame_t exp_q[$];
  int     starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();
  uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp(int dl);
    return (dl == 0 || dl > DATA_W) ? DATA_W : dl;
  endfunction

  task automatic run_frame(frame_t f);
    logic bits[$];
    logic p, act;
    int   len, total, ndone;
    bit   done_last;
    len = clamp(f.len);
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      bits.push_back(f.d[DATA_W-1-i]);
      p ^= f.d[DATA_W-1-i];
    end
    if (f.par && PAR_BUILT) bits.push_back(p ^ f.odd);
    bits.push_back(1'b1);
    if (f.st2) bits.push_back(1'b1);
    starts.push_back(cyc);
    total = 0; ndone = 0; done_last = 1'b0;
    for (int b = 0; b < bits.size(); b++) begin
      act = bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (rst) return;
        if (bus.serial_out !== bits[b]) act = bus.serial_out;
        if (bus.done === 1'b1) begin
          ndone++;
          if (b == bits.size() - 1 && c == CPB - 1) done_last = 1'b1;
        end
        total++;
        if (!(b == bits.size() - 1 && c == CPB - 1)) @(negedge clk);
      end
      chk($sformatf("frame_bit%0d", b), act, bits[b]);
    end
    chk("done_count", ndone, 1);
    chk("done_last_cycle", done_last, 1);
    last_len = total;
  endtask

  // Line monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.serial_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          for (int k = 0; k < 200 && bus.serial_out !== 1'b1; k++) @(negedge clk);
        end else begin
          run_frame(exp_q.pop_front());
        end
      end else if (!rst) begin
        chk("done_idle", bus.done, 0);
      end
    end
  end

  task automatic push(logic [DATA_W-1:0] d, bit accept);
    @(negedge clk);
    if (accept) exp_q.push_back('{d: d, len: int'(bus.data_len), par: bus.parity_en,
                                  odd: bus.parity_odd, st2: bus.stop2});
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", (n < max), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.data_len = 4'd14; bus.stop2 = 1'b0;
    bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.rx_rts = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_serial", bus.serial_out, 1);
    chk("rst_state", bus.state, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;

    // 14-bit frame, one stop bit; config changes mid-frame must not matter
    bus.rx_rts = 1'b1;
    push(14'h2A5C, 1'b1);
    chk("lat_count1", bus.count, 1);
    chk("lat_idle_line", bus.serial_out, 1);
    @(negedge clk);
    chk("lat_state_start", bus.state, 1);
    chk("lat_busy", bus.busy, 1);
    chk("lat_count0", bus.count, 0);
    chk("lat_line_low", bus.serial_out, 0);
    bus.data_len = 4'd3; bus.stop2 = 1'b1;
    wait_idle(300);
    chk("len_14_1stop", last_len, 64);
    bus.data_len = 4'd14; bus.stop2 = 1'b0;

    // 8 ones with odd parity
    bus.data_len = 4'd8; bus.parity_en = 1'b1; bus.parity_odd = 1'b1;
    push(14'h3FC0, 1'b1);
    wait_idle(300);
    chk("len_parity", last_len, PAR_BUILT ? 44 : 40);
    bus.data_len = 4'd14; bus.parity_en = 1'b0; bus.parity_odd = 1'b0;

    // Fill while far end not ready; fifth write dropped
    bus.rx_rts = 1'b0;
    push(14'h0001, 1'b1);
    push(14'h1555, 1'b1);
    push(14'h2AAA, 1'b1);
    push(14'h3FFF, 1'b1);
    push(14'h1234, 1'b0);
    chk("full_flag", bus.full, 1);
    chk("full_count", bus.count, 4);
    chk("full_line_idle", bus.serial_out, 1);
    chk("full_state_idle", bus.state, 0);
    starts.delete();
    bus.rx_rts = 1'b1;
    wait_idle(1200);
    chk("b2b_frames", starts.size(), 4);
    for (int i = 1; i < 4; i++)
      if (i < starts.size()) chk($sformatf("b2b_gap%0d", i), starts[i] - starts[i-1], 64);

    // data_len=0 means full width, two stop bits
    bus.stop2 = 1'b1; bus.data_len = 4'd0;
    push(14'h0F0F, 1'b1);
    wait_idle(300);
    chk("len_stop2", last_len, 68);
    bus.stop2 = 1'b0; bus.data_len = 4'd14;

    // rx_rts dropped mid-frame: current frame completes, next waits
    push(14'h1111, 1'b1);
    push(14'h2222, 1'b1);
    repeat (10) @(negedge clk);
    chk("rts_in_data", bus.state, 2);
    bus.rx_rts = 1'b0;
    for (int k = 0; k < 200 && bus.busy !== 1'b0; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("rts_held_count", bus.count, 1);
    chk("rts_held_busy", bus.busy, 0);
    chk("rts_held_pending", exp_q.size(), 1);
    bus.rx_rts = 1'b1;
    wait_idle(300);
    chk("rts_resume_count", bus.count, 0);

    // Reset mid-DATA with two words queued
    push(14'h0AAA, 1'b1);
    push(14'h1555, 1'b1);
    push(14'h3333, 1'b1);
    repeat (8) @(negedge clk);
    chk("rstmid_in_data", bus.state, 2);
    chk("rstmid_queued", bus.count, 2);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_serial", bus.serial_out, 1);
    chk("rstmid_state", bus.state, 0);
    chk("rstmid_count", bus.count, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      bit low_seen, done_seen;
      low_seen = 1'b0; done_seen = 1'b0;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        if (bus.serial_out !== 1'b1) low_seen = 1'b1;
        if (bus.done !== 1'b0) done_seen = 1'b1;
      end
      chk("post_rst_line_idle", low_seen, 0);
      chk("post_rst_no_done", done_seen, 0);
      chk("post_rst_count", bus.count, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
